// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle core: one word access per request,
// completion pulse after WAIT_CYCLES, faulting accesses flagged instead of performed.
module mem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req,
    input  logic [31:0]           Adr,
    input  logic [31:0]           WriteData,
    input  logic                  MemWrite,
    input  logic                  LoadEn,
    input  logic [DEPTH_LOG2-1:0] LoadAdr,
    input  logic [31:0]           LoadData,
    output logic [31:0]           ReadData,
    output logic                  Ready,
    output logic                  Fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam bit         HAS_WAIT    = (WAIT_CYCLES > 0);
    localparam int         WAIT_LOAD_I = HAS_WAIT ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_LOAD_I);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [3:0]            cnt;

    logic [31:0]           adr_q;
    logic [31:0]           wdata_q;
    logic                  write_q;

    logic [31:0]           acc_adr;
    logic [31:0]           acc_wdata;
    logic                  acc_write;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_fault;
    logic                  commit;
    logic                  load_we;
    logic                  store_we;
    logic [31:0]           rd_word;

    logic [31:0]           mem [DEPTH];

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (Req) next_state = HAS_WAIT ? S_WAIT : S_DONE;
            S_WAIT: if (cnt == 4'd0) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With zero wait states the access commits on the acceptance edge, so it
    // must be taken straight from the ports rather than from the latch.
    always_comb begin
        acc_adr   = (state == S_IDLE) ? Adr       : adr_q;
        acc_wdata = (state == S_IDLE) ? WriteData : wdata_q;
        acc_write = (state == S_IDLE) ? MemWrite  : write_q;
    end

    assign acc_idx   = acc_adr[DEPTH_LOG2+1:2];
    assign acc_fault = is_fault(acc_adr);
    assign commit    = (next_state == S_DONE);
    assign load_we   = LoadEn && (state == S_IDLE);
    assign store_we  = commit && acc_write && !acc_fault && reset;

    // A same-edge side load wins over the array contents for the committing read.
    assign rd_word = (load_we && (LoadAdr == acc_idx)) ? LoadData : mem[acc_idx];

    // Control stage: FSM, wait counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            Ready    <= 1'b0;
            Fault    <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && Req) begin
                cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            Ready <= commit;
            Fault <= commit && acc_fault;
            if (commit) begin
                if (acc_fault) begin
                    ReadData <= 32'd0;
                end else if (!acc_write) begin
                    ReadData <= rd_word;
                end
            end
        end
    end

    // Request latch: data only, qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && Req) begin
            adr_q   <= Adr;
            wdata_q <= WriteData;
            write_q <= MemWrite;
        end
    end

    // Storage: side-load port and core store port; the array is never cleared.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[LoadAdr] <= LoadData;
        end
        if (store_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule
